// File: rtl/rc5_key_sched_pkg.sv
`default_nettype none
// ============================================================================
// rc5_key_sched_pkg : FSM state encoding and constants for the key scheduler
// Revision: 1.0
// ============================================================================
package rc5_key_sched_pkg;

  localparam int KEY_W         = 128;
  localparam int RC5_KEYEX_LAT = 78;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_WAIT = 3'd2,
    ST_ACK  = 3'd3,
    ST_ERR  = 3'd4
  } state_e;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rc5_key_sched_rr_arb.sv
`default_nettype none
// ============================================================================
// rc5_key_sched_rr_arb : combinational round-robin picker, first request at
//                        or after the pointer, wrapping NREQ-1 -> 0
// Revision: 1.0
// ============================================================================
module rc5_key_sched_rr_arb #(
  parameter int NREQ = 2,
  parameter int ID_W = 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [ID_W-1:0] ptr_i,
  output logic [ID_W-1:0] sel_o,
  output logic            any_o
);

  // Scan from the farthest offset down so the nearest request wins last.
  always_comb begin
    int idx;
    idx   = 0;
    sel_o = '0;
    any_o = 1'b0;
    for (int off = NREQ - 1; off >= 0; off--) begin
      idx = int'(ptr_i) + off;
      if (idx >= NREQ) idx = idx - NREQ;
      if (req_i[idx]) begin
        sel_o = ID_W'(idx);
        any_o = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/rc5_key_sched.sv
`default_nettype none
// ============================================================================
// rc5_key_sched : arbitrates channel key-load requests onto one rc5_keyex and
//                 tracks which channel/key currently owns the round-key schedule
// Revision: 1.0
// ============================================================================
module rc5_key_sched
  import rc5_key_sched_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int ID_W    = id_width(NREQ),
  parameter int TIMEOUT = 100
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [NREQ-1:0]       i_req,
  input  logic [KEY_W*NREQ-1:0] i_key,
  input  logic                  i_flush,
  output logic [NREQ-1:0]       o_ack,
  output logic [KEY_W-1:0]      o_kx_key,
  output logic                  o_kx_key_en,
  input  logic                  i_kx_key_ok,
  output logic                  o_cur_valid,
  output logic [ID_W-1:0]       o_cur_id,
  output logic                  o_busy,
  output logic                  o_err
);

  localparam int WDOG_W = $clog2(TIMEOUT);

  state_e             state_q;
  logic [ID_W-1:0]    ptr_q, sel_q, cur_id_q;
  logic [KEY_W-1:0]   tag_q, kx_key_q;
  logic [NREQ-1:0]    ack_q;
  logic               kx_en_q, cur_valid_q, err_q;
  logic [WDOG_W-1:0]  wdog_q;

  logic [ID_W-1:0]    w_sel;
  logic               w_any, w_hit;
  logic [KEY_W-1:0]   w_sel_key;

  rc5_key_sched_rr_arb #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_arb (
    .req_i (i_req),
    .ptr_i (ptr_q),
    .sel_o (w_sel),
    .any_o (w_any)
  );

  assign w_sel_key = i_key[int'(w_sel)*KEY_W +: KEY_W];
  assign w_hit     = cur_valid_q && (cur_id_q == w_sel) && (w_sel_key == tag_q);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      sel_q       <= '0;
      cur_id_q    <= '0;
      tag_q       <= '0;
      kx_key_q    <= '0;
      ack_q       <= '0;
      kx_en_q     <= 1'b0;
      cur_valid_q <= 1'b0;
      err_q       <= 1'b0;
      wdog_q      <= '0;
    end else if (i_flush) begin
      // Pointer and last driven key survive; a pulsed expander just finishes.
      state_q     <= ST_IDLE;
      ack_q       <= '0;
      kx_en_q     <= 1'b0;
      cur_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      ack_q   <= '0;
      kx_en_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (w_any) begin
            sel_q <= w_sel;
            if (w_hit) begin
              state_q <= ST_ACK;
              ack_q   <= NREQ'(1) << w_sel;
            end else begin
              state_q     <= ST_LOAD;
              kx_key_q    <= w_sel_key;
              kx_en_q     <= 1'b1;
              cur_valid_q <= 1'b0;
            end
          end
        end
        ST_LOAD: begin
          wdog_q  <= '0;
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (i_kx_key_ok) begin
            tag_q       <= kx_key_q;
            cur_id_q    <= sel_q;
            cur_valid_q <= 1'b1;
            if (i_req[sel_q]) begin
              state_q <= ST_ACK;
              ack_q   <= NREQ'(1) << sel_q;
            end else begin
              state_q <= ST_IDLE;
            end
          end else if (wdog_q == WDOG_W'(TIMEOUT - 1)) begin
            state_q <= ST_ERR;
            err_q   <= 1'b1;
          end else begin
            wdog_q <= wdog_q + WDOG_W'(1);
          end
        end
        ST_ACK: begin
          ptr_q   <= (sel_q == ID_W'(NREQ - 1)) ? '0 : sel_q + ID_W'(1);
          state_q <= ST_IDLE;
        end
        ST_ERR:  state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_ack       = ack_q;
  assign o_kx_key    = kx_key_q;
  assign o_kx_key_en = kx_en_q;
  assign o_cur_valid = cur_valid_q;
  assign o_cur_id    = cur_id_q;
  assign o_busy      = (state_q != ST_IDLE);
  assign o_err       = err_q;

endmodule
`default_nettype wire
